mpss_mailbox: RTL and testbench

//  Inter-tile message FIFO exposed as an xbar slave port (sN_* side of the xbar_nobuf fabric).
//  Any master (tile xbus, udm) pushes 32-bit words by writing DATA; the consumer core pops by reading DATA.

---
 rtl/mpss_mailbox_pkg.sv | 34 +++
 rtl/mpss_mailbox_fifo.sv | 55 +++++
 rtl/mpss_mailbox.sv | 98 +++++++++
 tb/tb_mpss_mailbox.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mpss_mailbox_pkg.sv
// Shared definitions for the mpss mailbox: register offsets, STATUS/CTRL bit
// positions and the STATUS word packing helper.
package mpss_mailbox_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_PEEK   = 2'd3
  } reg_sel_e;

  localparam int BUS_W          = 32;
  localparam int STAT_FULL_BIT  = 8;
  localparam int STAT_EMPTY_BIT = 9;
  localparam int STAT_OVF_BIT   = 16;
  localparam int STAT_UNF_BIT   = 17;
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  function automatic logic [BUS_W-1:0] status_word(input logic [BUS_W-1:0] cnt,
                                                   input logic full,
                                                   input logic empty,
                                                   input logic ovf,
                                                   input logic unf);
    logic [BUS_W-1:0] w;
    w                 = cnt;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_UNF_BIT]   = unf;
    return w;
  endfunction

endpackage

// File: rtl/mpss_mailbox_fifo.sv
// Flop-array FIFO with occupancy count; push and pop are never issued in the
// same cycle by the bus decoder, flush clears pointers and count.
module mpss_mailbox_fifo
  import mpss_mailbox_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int DATA_W = BUS_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      count  <= count + CNT_W'(1);
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mpss_mailbox.sv
// Inter-tile mailbox on an xbar slave port: bus decode, one-cycle read
// response, sticky overflow/underflow flags and a level not-empty interrupt.
module mpss_mailbox
  import mpss_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [3:0]       bus_be,
  input  logic [31:0]      bus_wdata,
  output logic             bus_ack,
  output logic             bus_resp,
  output logic [31:0]      bus_rdata,
  output logic             irq_o,
  output logic [CNT_W-1:0] count_o
);

  reg_sel_e          sel;
  logic              acc_wr, acc_rd;
  logic              push, pop, flush, clr_flags;
  logic              full, empty;
  logic              ovf, unf;
  logic [BUS_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic [BUS_W-1:0]  rd_data;

  assign sel       = reg_sel_e'(bus_addr[3:2]);
  assign acc_wr    = bus_req & bus_we;
  assign acc_rd    = bus_req & ~bus_we;
  assign push      = acc_wr & (sel == REG_DATA) & ~full;
  assign pop       = acc_rd & (sel == REG_DATA) & ~empty;
  assign flush     = acc_wr & (sel == REG_CTRL) & bus_be[0] & bus_wdata[CTRL_FLUSH_BIT];
  assign clr_flags = acc_wr & (sel == REG_CTRL) & bus_be[0] & bus_wdata[CTRL_CLR_BIT];

  mpss_mailbox_fifo #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .DATA_W (BUS_W)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus_wdata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Read mux sees pre-edge state, so a pop returns the old head.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_DATA:   rd_data = empty ? '0 : head;
      REG_STATUS: rd_data = status_word(BUS_W'(count), full, empty, ovf, unf);
      REG_PEEK:   rd_data = empty ? '0 : head;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus_resp  <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_resp  <= acc_rd;
      bus_rdata <= acc_rd ? rd_data : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (clr_flags) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (acc_wr && sel == REG_DATA && full)  ovf <= 1'b1;
      if (acc_rd && sel == REG_DATA && empty) unf <= 1'b1;
    end
  end

  assign bus_ack = bus_req;
  assign irq_o   = ~empty;
  assign count_o = count;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_be[3:1]};

endmodule

// File: tb/tb_mpss_mailbox.sv
// Directed bench for mpss_mailbox: read expectations go into a scoreboard
// queue and are matched against each bus_resp by a negedge monitor.
module tb_mpss_mailbox;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             bus_req;
  logic             bus_we;
  logic [31:0]      bus_addr;
  logic [3:0]       bus_be;
  logic [31:0]      bus_wdata;
  logic             bus_ack;
  logic             bus_resp;
  logic [31:0]      bus_rdata;
  logic             irq_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;
  localparam logic [31:0] A_PEEK   = 32'hC;

  always #5 clk_i = ~clk_i;

  mpss_mailbox #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_resp  (bus_resp),
    .bus_rdata (bus_rdata),
    .irq_o     (irq_o),
    .count_o   (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest queued read.
  always @(negedge clk_i) begin
    if (bus_resp === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        chk("rdata", bus_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic nop();
    @(negedge clk_i);
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_be = '0; bus_wdata = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk_i);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_be = be; bus_wdata = data;
    chk("ack_wr", 32'(bus_ack), 32'd1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk_i);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_be = 4'hF; bus_wdata = '0;
    exp_q.push_back(exp);
  endtask

  initial begin
    rst_i = 1'b0;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_be = '0; bus_wdata = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_resp", 32'(bus_resp), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rst_i = 1'b1;
    rd(A_STATUS, 32'h0000_0200);
    nop();

    // Basic push then back-to-back pops
    wr(A_DATA, 32'h11, 4'hF);
    wr(A_DATA, 32'h22, 4'hF);
    wr(A_DATA, 32'h33, 4'hF);
    nop();
    chk("cnt3", 32'(count_o), 32'd3);
    chk("irq_set", 32'(irq_o), 32'd1);
    rd(A_DATA, 32'h11);
    rd(A_DATA, 32'h22);
    chk("b2b_resp1", 32'(bus_resp), 32'd1);
    rd(A_DATA, 32'h33);
    chk("b2b_resp2", 32'(bus_resp), 32'd1);
    nop();
    chk("b2b_resp3", 32'(bus_resp), 32'd1);
    chk("irq_drop", 32'(irq_o), 32'd0);
    nop();
    chk("resp_idle", 32'(bus_resp), 32'd0);

    // Overflow: DEPTH+1 pushes
    for (int i = 1; i <= DEPTH + 1; i++) wr(A_DATA, 32'(i), 4'hF);
    rd(A_STATUS, 32'h0001_0108);
    for (int i = 1; i <= DEPTH; i++) rd(A_DATA, 32'(i));
    rd(A_STATUS, 32'h0001_0200);
    nop();

    // Underflow, peek on empty, flag clear
    rd(A_DATA, 32'h0);
    rd(A_STATUS, 32'h0003_0200);
    rd(A_PEEK, 32'h0);
    rd(A_STATUS, 32'h0003_0200);
    wr(A_CTRL, 32'h2, 4'hF);
    rd(A_STATUS, 32'h0000_0200);
    rd(A_CTRL, 32'h0);
    nop();

    // Pointer wrap
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'hA0 + 32'(i), 4'hF);
    for (int i = 0; i < 3; i++) rd(A_DATA, 32'hA0 + 32'(i));
    nop();
    chk("wrap_cnt2", 32'(count_o), 32'd2);
    for (int i = 0; i < 6; i++) wr(A_DATA, 32'hB0 + 32'(i), 4'hF);
    nop();
    chk("wrap_cnt8", 32'(count_o), 32'd8);
    rd(A_PEEK, 32'hA3);
    rd(A_DATA, 32'hA3);
    chk("wrap_pop_cnt0", 32'(count_o), 32'd8);
    rd(A_DATA, 32'hA4);
    chk("wrap_pop_cnt1", 32'(count_o), 32'd7);
    for (int i = 0; i < 6; i++) begin
      rd(A_DATA, 32'hB0 + 32'(i));
      chk("wrap_pop_cnt", 32'(count_o), 32'(6 - i));
    end
    nop();
    chk("wrap_empty", 32'(count_o), 32'd0);

    // Flush gated by be[0]
    wr(A_DATA, 32'hC0, 4'hF);
    wr(A_DATA, 32'hC1, 4'hF);
    wr(A_CTRL, 32'h1, 4'h0);
    nop();
    chk("flush_be0_cnt", 32'(count_o), 32'd2);
    wr(A_CTRL, 32'h1, 4'h1);
    nop();
    chk("flush_cnt", 32'(count_o), 32'd0);
    chk("flush_irq", 32'(irq_o), 32'd0);
    rd(A_STATUS, 32'h0000_0200);
    nop();

    // Reset dominates a same-cycle DATA read
    wr(A_DATA, 32'hD0, 4'hF);
    @(negedge clk_i);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_DATA; bus_be = 4'hF;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_read_resp", 32'(bus_resp), 32'd0);
    chk("rst_read_cnt", 32'(count_o), 32'd0);
    rst_i = 1'b1;
    bus_req = 1'b0;
    nop();
    chk("rst_read_resp2", 32'(bus_resp), 32'd0);
    rd(A_STATUS, 32'h0000_0200);
    nop();
    nop();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
